write_pointer_full: RTL and testbench

- Write-domain pointer and full-flag stage of the asynchronous FIFO.
- Consumes the 2-FF-synchronised Gray read pointer and the producer's write request.
- Keeps the binary and Gray write pointers, drives the dual-port RAM write address and strobe, and generates registered full, almost-full and fill-level status.
- Its Gray write pointer output feeds the write-to-read synchroniser.

---
 rtl/write_pointer_full_pkg.sv | 29 ++
 rtl/write_pointer_full_gray_to_binary.sv | 16 +
 rtl/write_pointer_full.sv | 85 ++++++++
 tb/tb_write_pointer_full.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/write_pointer_full_pkg.sv
// Shared Gray/binary helpers for the async FIFO pointer stages (write-full and read-empty).
package write_pointer_full_pkg;

  localparam int DEFAULT_ADDRESS_SIZE = 3;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 1; i < 32; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

  // Full when the pointers match except the top two bits, which are inverted.
  // Both operands must be zero-extended pointers of the given width (>= 2).
  function automatic logic gray_full_match(input logic [31:0] wgray,
                                           input logic [31:0] rgray,
                                           input int          width);
    logic [31:0] mask;
    mask = 32'd3 << (width - 2);
    return wgray == (rgray ^ mask);
  endfunction

endpackage

// File: rtl/write_pointer_full_gray_to_binary.sv
// Parameterised Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_binary #(
  parameter int width = 4
) (
  input  logic [width-1:0] gray,
  output logic [width-1:0] bin
);

  assign bin[width-1] = gray[width-1];

  genvar i;
  for (i = 0; i < width - 1; i++) begin : g_bit
    assign bin[i] = ^gray[width-1:i];
  end

endmodule

// File: rtl/write_pointer_full.sv
// Write-domain pointer, RAM write strobe and registered full/almost-full/level status of the async FIFO.
// Optional sticky overflow flag enabled by defining WRITE_OVERFLOW_FLAG_EN.
module write_pointer_full
  import write_pointer_full_pkg::*;
#(
  parameter int address_size       = DEFAULT_ADDRESS_SIZE,
  parameter int almost_full_margin = 2
) (
  input  logic                  write_clk,
  input  logic                  write_reset_n,
  input  logic                  write_inc,
  input  logic [address_size:0] write_to_read_pointer,
  input  logic                  write_overflow_clear,
  output logic                  write_enable,
  output logic [address_size-1:0] write_address,
  output logic [address_size:0] write_pointer,
  output logic                  write_full,
  output logic                  write_almost_full,
  output logic [address_size:0] write_level,
  output logic                  write_overflow
);

  localparam int pw    = address_size + 1;
  localparam int depth = 1 << address_size;
  localparam logic [address_size:0] af_threshold = pw'(depth - almost_full_margin);

  logic [address_size:0] bin_q;
  logic [address_size:0] bin_next;
  logic [address_size:0] gray_next;
  logic [address_size:0] rbin;
  logic [address_size:0] level_next;
  logic                  full_next;

  gray_to_binary #(.width(pw)) u_rq_g2b (
    .gray (write_to_read_pointer),
    .bin  (rbin)
  );

  // Handshake: write_inc is the producer's request; write_enable is the accept
  // strobe, high only when not full. A request is consumed on the edge where
  // write_enable is high; a refused request is dropped, not held pending.
  assign write_enable  = write_inc & ~write_full;
  assign write_address = bin_q[address_size-1:0];

  always_comb begin
    bin_next   = bin_q + {{address_size{1'b0}}, write_enable};
    gray_next  = pw'(bin2gray(32'(bin_next)));
    full_next  = gray_full_match(32'(gray_next), 32'(write_to_read_pointer), pw);
    level_next = bin_next - rbin;
  end

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      bin_q             <= '0;
      write_pointer     <= '0;
      write_full        <= 1'b0;
      write_almost_full <= 1'b0;
      write_level       <= '0;
    end else begin
      bin_q             <= bin_next;
      write_pointer     <= gray_next;
      write_full        <= full_next;
      write_almost_full <= level_next >= af_threshold;
      write_level       <= level_next;
    end
  end

`ifdef WRITE_OVERFLOW_FLAG_EN
  // A new overflow in the same cycle as a clear wins, so no event is lost.
  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      write_overflow <= 1'b0;
    end else if (write_inc && write_full) begin
      write_overflow <= 1'b1;
    end else if (write_overflow_clear) begin
      write_overflow <= 1'b0;
    end
  end
`else
  logic unused_overflow_clear;
  assign unused_overflow_clear = write_overflow_clear;
  assign write_overflow        = 1'b0;
`endif

endmodule

// File: tb/tb_write_pointer_full.sv
// Randomised scoreboard bench for write_pointer_full (address_size=3, depth 8, margin 2).
module tb_write_pointer_full;

  localparam int AS    = 3;
  localparam int DEPTH = 8;
  localparam int MOD   = 16;

  logic          write_clk;
  logic          write_reset_n;
  logic          write_inc;
  logic [AS:0]   write_to_read_pointer;
  logic          write_overflow_clear;
  logic          write_enable;
  logic [AS-1:0] write_address;
  logic [AS:0]   write_pointer;
  logic          write_full;
  logic          write_almost_full;
  logic [AS:0]   write_level;
  logic          write_overflow;

  write_pointer_full #(.address_size(AS), .almost_full_margin(2)) dut (
    .write_clk             (write_clk),
    .write_reset_n         (write_reset_n),
    .write_inc             (write_inc),
    .write_to_read_pointer (write_to_read_pointer),
    .write_overflow_clear  (write_overflow_clear),
    .write_enable          (write_enable),
    .write_address         (write_address),
    .write_pointer         (write_pointer),
    .write_full            (write_full),
    .write_almost_full     (write_almost_full),
    .write_level           (write_level),
    .write_overflow        (write_overflow)
  );

  // ---------------- clock / reset ----------------
  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  // ---------------- scoreboard state ----------------
  // packed: {we, addr[2:0], ptr[3:0], full, af, level[3:0], ovf}
  logic [14:0] exp_q[$];
  int          checks;
  int          errors;
  logic [AS:0] prev_ptr;

  // reference model: unbounded write/read counts
  int   m_writes;
  int   m_reads;
  logic m_full;
  logic m_ovf;

  function automatic logic [AS:0] to_gray(input int count);
    int b;
    b = count % MOD;
    return (AS+1)'(b ^ (b >> 1));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_writes = 0;
    m_reads  = 0;
    m_full   = 1'b0;
    m_ovf    = 1'b0;
    prev_ptr = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ptr"},   int'(write_pointer), 0);
    check({tag, "_full"},  int'(write_full), 0);
    check({tag, "_af"},    int'(write_almost_full), 0);
    check({tag, "_level"}, int'(write_level), 0);
    check({tag, "_ovf"},   int'(write_overflow), 0);
    check({tag, "_addr"},  int'(write_address), 0);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic inc, input int reads, input logic clr);
    logic       we;
    int         addr;
    int         level;
    logic       af;
    @(negedge write_clk);
    write_inc             = inc;
    write_to_read_pointer = to_gray(reads);
    write_overflow_clear  = clr;
    m_reads = reads;
    we   = inc && !m_full;
    addr = m_writes % DEPTH;
`ifdef WRITE_OVERFLOW_FLAG_EN
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
`endif
    if (we) m_writes++;
    level  = m_writes - m_reads;
    m_full = (level == DEPTH);
    af     = (level >= DEPTH - 2);
    exp_q.push_back({we, 3'(addr), to_gray(m_writes), m_full, af, 4'(level), m_ovf});
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        s_we;
    logic [2:0]  s_addr;
    logic [14:0] e;
    forever begin
      @(negedge write_clk);
      #2;
      if (exp_q.size() == 0) continue;
      s_we   = write_enable;
      s_addr = write_address;
      @(posedge write_clk);
      #1;
      e = exp_q.pop_front();
      check("write_enable",  int'(s_we), int'(e[14]));
      if (e[14]) check("write_address", int'(s_addr), int'(e[13:11]));
      check("write_pointer", int'(write_pointer), int'(e[10:7]));
      check("write_full",    int'(write_full), int'(e[6]));
      check("almost_full",   int'(write_almost_full), int'(e[5]));
      check("write_level",   int'(write_level), int'(e[4:1]));
      check("overflow",      int'(write_overflow), int'(e[0]));
      check("gray_one_bit",  int'($countones(write_pointer ^ prev_ptr) <= 1), 1);
      prev_ptr = write_pointer;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rc;
    checks = 0;
    errors = 0;
    model_reset();
    write_reset_n         = 1'b0;
    write_inc             = 1'b1;
    write_to_read_pointer = '0;
    write_overflow_clear  = 1'b0;
    repeat (2) @(negedge write_clk);
    check_reset_outputs("reset");
    write_inc     = 1'b0;
    write_reset_n = 1'b1;

    // fill to full: addresses 0..7, first pointer 0001
    for (int i = 0; i < DEPTH; i++) step(1'b1, 0, 1'b0);
    // rejected writes while full, then clear overflow
    step(1'b1, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    // one read seen: full drops, level 7
    step(1'b0, 1, 1'b0);
    // write together with a read advance at level 7
    step(1'b1, 2, 1'b0);
    // settle at level 2 then wrap with the reader tracking two behind
    step(1'b0, m_writes - 2, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, m_writes - 1, 1'b0);

    // randomised traffic
    rc = m_reads;
    for (int i = 0; i < 300; i++) begin
      if (rc < m_writes && $urandom_range(0, 99) < 45) rc++;
      step(($urandom_range(0, 3) != 0), rc, ($urandom_range(0, 7) == 0));
    end

    // asynchronous reset in mid-cycle
    @(posedge write_clk);
    #3;
    write_reset_n = 1'b0;
    write_inc     = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    @(negedge write_clk);
    write_to_read_pointer = '0;
    write_reset_n = 1'b1;
    rc = 0;
    for (int i = 0; i < 60; i++) begin
      if (rc < m_writes && $urandom_range(0, 99) < 40) rc++;
      step(($urandom_range(0, 3) != 0), rc, ($urandom_range(0, 5) == 0));
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge write_clk);
    #2;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
